// File: rtl/pc_fetch_sequencer_if.sv
// Fetch bus: imem request/ready handshake plus the decode-facing
// delivery signals (valid, pc, stall, squash).
interface pc_fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] pc_plus4;
   logic        squash;
   logic        stall;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      output fetch_valid,
      output fetch_pc,
      output pc_plus4,
      output squash,
      input  stall
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      input  fetch_valid,
      input  fetch_pc,
      input  pc_plus4,
      input  squash,
      output stall
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC sequencer: BOOT/FETCH/DELIVER FSM with a one-entry prioritised
// redirect register; redirects squash the outstanding fetch.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        exception,
   pc_fetch_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      FETCH   = 2'd1,
      DELIVER = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic        squash_q, squash_d;
   logic        pend_vld_q, pend_vld_d;
   logic [1:0]  pend_rank_q, pend_rank_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;

   logic [1:0]  arr_rank;
   logic [31:0] arr_tgt;
   logic        take_arr;
   logic        mrg_vld;
   logic [1:0]  mrg_rank;
   logic [31:0] mrg_tgt;

   // Rank 3 = exception, 2 = jump, 1 = branch, 0 = none.
   always_comb begin
      arr_rank = 2'd0;
      arr_tgt  = 32'h0;
      if (exception) begin
         arr_rank = 2'd3;
         arr_tgt  = EXC_VECTOR;
      end else if (jump) begin
         arr_rank = 2'd2;
         arr_tgt  = jump_target;
      end else if (branch_taken) begin
         arr_rank = 2'd1;
         arr_tgt  = branch_target;
      end
      arr_tgt[1:0] = 2'b00;
   end

   always_comb begin
      take_arr = (arr_rank != 2'd0) &&
                 (!pend_vld_q || (arr_rank >= pend_rank_q));
      mrg_vld  = pend_vld_q | (arr_rank != 2'd0);
      mrg_rank = take_arr ? arr_rank : pend_rank_q;
      mrg_tgt  = take_arr ? arr_tgt : pend_tgt_q;
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      pc_d        = pc_q;
      pc4_d       = pc4_q;
      squash_d    = 1'b0;
      pend_vld_d  = pend_vld_q;
      pend_rank_d = pend_rank_q;
      pend_tgt_d  = pend_tgt_q;
      case (state_q)
         BOOT: begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = RESET_VECTOR;
         end
         FETCH: begin
            if (bus.imem_ready) begin
               if (mrg_vld) begin
                  squash_d    = 1'b1;
                  addr_d      = mrg_tgt;
                  pend_vld_d  = 1'b0;
                  pend_rank_d = 2'd0;
               end else begin
                  state_d = DELIVER;
                  req_d   = 1'b0;
                  valid_d = 1'b1;
                  pc_d    = addr_q;
                  pc4_d   = addr_q + 32'd4;
               end
            end else begin
               pend_vld_d  = mrg_vld;
               pend_rank_d = mrg_rank;
               pend_tgt_d  = mrg_tgt;
            end
         end
         DELIVER: begin
            if (bus.stall) begin
               pend_vld_d  = mrg_vld;
               pend_rank_d = mrg_rank;
               pend_tgt_d  = mrg_tgt;
            end else begin
               state_d     = FETCH;
               req_d       = 1'b1;
               valid_d     = 1'b0;
               addr_d      = mrg_vld ? mrg_tgt : pc4_q;
               pend_vld_d  = 1'b0;
               pend_rank_d = 2'd0;
            end
         end
         default: begin
            state_d = BOOT;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= BOOT;
         req_q       <= 1'b0;
         addr_q      <= RESET_VECTOR;
         valid_q     <= 1'b0;
         pc_q        <= 32'h0;
         pc4_q       <= 32'd4;
         squash_q    <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_rank_q <= 2'd0;
         pend_tgt_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         pc4_q       <= pc4_d;
         squash_q    <= squash_d;
         pend_vld_q  <= pend_vld_d;
         pend_rank_q <= pend_rank_d;
         pend_tgt_q  <= pend_tgt_d;
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = addr_q;
   assign bus.fetch_valid = valid_q;
   assign bus.fetch_pc    = pc_q;
   assign bus.pc_plus4    = pc4_q;
   assign bus.squash      = squash_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Sequences the program counter and instruction-memory fetch for the mips32 core. Replaces the free-running ProgramCounter/Add_Pc pairing with a controlled FSM. Each cycle it selects the next PC from PC+4, branch target, jump target or exception vector. It runs a req/ready handshake to instruction memory and presents each fetched instruction address to decode under a stall-aware valid. Redirects arriving while a fetch is outstanding squash that fetch.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
EXC_VECTOR, 32'h8000_0180, exception handler address

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  decode cannot accept; holds delivered instruction
branch_taken  input  1  single-cycle pulse: redirect to branch_target
branch_target  input  32  branch destination
jump  input  1  single-cycle pulse: redirect to jump_target
jump_target  input  32  jump destination
exception  input  1  single-cycle pulse: redirect to EXC_VECTOR
imem_ready  input  1  memory accepts current request this cycle
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
fetch_valid  output  1  fetch_pc holds a delivered, unsquashed instruction
fetch_pc  output  32  address of delivered instruction
pc_plus4  output  32  fetch_pc + 4, for link/branch calculation
squash  output  1  one-cycle pulse when an outstanding fetch is discarded

Behaviour:
- Reset (sampled on clk edge while reset=1): state BOOT; imem_req=0, imem_addr=RESET_VECTOR, fetch_valid=0, fetch_pc=0, pc_plus4=4, squash=0, pending redirect cleared. Reset mid-handshake abandons the request without waiting for ready.
- States: BOOT, FETCH, DELIVER.
- BOOT: lasts exactly one cycle after reset deasserts; then goes to FETCH with imem_addr=RESET_VECTOR.
- FETCH: imem_req=1, fetch_valid=0.
  - imem_addr must stay constant until accept; accept = imem_req & imem_ready at a clk edge.
  - On accept with no redirect pending and none arriving this cycle: go to DELIVER; fetch_pc <= imem_addr, pc_plus4 <= imem_addr+4.
  - On accept with a redirect pending or arriving: do not deliver. Pulse squash=1 next cycle, stay in FETCH, imem_addr <= redirect target, clear pending.
- DELIVER: fetch_valid=1, imem_req=0. The instruction is consumed on any cycle in DELIVER with stall=0.
  - stall=1: hold state; fetch_pc and pc_plus4 are unchanged.
  - stall=0: go to FETCH. imem_addr <= redirect target if a redirect is pending or arriving this cycle, else pc_plus4. Pending is cleared.
  - A redirect arriving in DELIVER never squashes the delivered instruction.
- Redirect capture: redirect pulses in any non-BOOT state are latched into a one-entry pending register (target plus valid).
  - Priority among simultaneous pulses: exception > jump > branch.
  - A new pulse replaces a pending entry only if it has equal or higher priority.
- Alignment: targets are forced to [1:0]=2'b00 before use.
- Arithmetic: all PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Throughput: minimum 2 cycles per delivered instruction (FETCH accept cycle plus DELIVER cycle). Zero-wait memory therefore gives fetch_valid every other cycle.

Test Plan:
- Reset then imem_ready tied 1, stall=0 -> BOOT 1 cycle; imem_addr 0,4,8,C sequence; fetch_valid alternates; fetch_pc 0,4,8 with pc_plus4 4,8,C.
- imem_ready held 0 for 3 cycles at addr 8 -> imem_req stays 1 and imem_addr stays 8 throughout; delivery of 8 occurs the cycle after ready rises.
- stall=1 for 4 cycles while fetch_pc=4 -> fetch_valid stays 1, fetch_pc stays 4, imem_req=0; after release next imem_addr=8.
- branch_taken pulse (target 32'h100) during outstanding fetch of 0xC -> 0xC not delivered; squash pulses; next imem_addr=32'h100; fetch_pc=32'h100.
- Simultaneous jump (0x200) and exception in DELIVER -> delivered instruction still valid; next fetch address EXC_VECTOR 32'h8000_0180; then branch pending while exception pending -> exception kept.
- Fetch at 32'hFFFF_FFFC -> next imem_addr 32'h0000_0000; jump_target 32'h203 -> fetch at 32'h200; reset asserted mid-FETCH -> imem_req=0 next cycle, restart at RESET_VECTOR.
